// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants for the scanned BCD counter
package bcd_pkg;
   localparam int          NUM_DIGITS       = 4;
   localparam logic [3:0]  BLANK_CODE       = 4'hF;
   localparam int          SCAN_DIV_DEFAULT = 12000;
endpackage

// File: rtl/bcd_scan_counter_if.sv
// rtl/bcd_scan_counter_if.sv - control inputs and display outputs of the scanned BCD counter
interface bcd_scan_counter_if;
   logic                                 inc;
   logic                                 clr;
   logic                                 en;
   logic [4*bcd_pkg::NUM_DIGITS-1:0]     count;
   logic                                 ovf;
   logic [3:0]                           bcd;
   logic [bcd_pkg::NUM_DIGITS-1:0]       dig_n;

   modport master (output inc, clr, en, input count, ovf, bcd, dig_n);
   modport slave  (input inc, clr, en, output count, ovf, bcd, dig_n);
endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the counter, rippling its carry to the next digit
module bcd_digit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       cin,
   output logic [3:0] value,
   output logic       cout
);
   always_ff @(posedge clk) begin
      if (!rst_n)
         value <= 4'd0;
      else if (clr)
         value <= 4'd0;
      else if (cin)
         value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
   end

   assign cout = cin && (value == 4'd9);
endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD event counter with multiplexed 7-segment scan
module bcd_scan_counter
   import bcd_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   bcd_scan_counter_if.slave  bus
);
   localparam int PW = $clog2(SCAN_DIV);

   logic                  inc_q;
   logic                  step;
   logic [NUM_DIGITS:0]   carry;
   logic [3:0]            digit [NUM_DIGITS];
   logic                  ovf_q;
   logic [PW-1:0]         psc;
   logic [1:0]            idx;
   logic                  blank;
   logic                  zero_run;
   logic [3:0]            sel;
   logic [3:0]            bcd_q;
   logic [NUM_DIGITS-1:0] dig_n_q;

   // Rising-edge detect keeps tracking inc even while counting is disabled.
   always_ff @(posedge clk) begin
      if (!rst_n)
         inc_q <= 1'b0;
      else
         inc_q <= bus.inc;
   end

   assign step     = bus.inc && !inc_q && bus.en && !bus.clr;
   assign carry[0] = step;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (bus.clr),
         .cin   (carry[g]),
         .value (digit[g]),
         .cout  (carry[g+1])
      );
      assign bus.count[4*g +: 4] = digit[g];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (bus.clr)
         ovf_q <= 1'b0;
      else if (carry[NUM_DIGITS])
         ovf_q <= 1'b1;
   end

   assign bus.ovf = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psc <= '0;
         idx <= 2'd0;
      end else if (psc == PW'(SCAN_DIV - 1)) begin
         psc <= '0;
         idx <= idx + 2'd1;
      end else begin
         psc <= psc + PW'(1);
      end
   end

   // A digit is a leading zero when it and every more significant digit are zero.
   always_comb begin
      blank    = 1'b0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (digit[k] == 4'd0);
         if (2'(k) == idx)
            blank = zero_run;
      end
      sel = (BLANK_LZ && blank) ? BLANK_CODE : digit[idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dig_n_q <= 4'b1110;
         bcd_q   <= 4'h0;
      end else begin
         dig_n_q <= ~(4'b0001 << idx);
         bcd_q   <= sel;
      end
   end

   assign bus.dig_n = dig_n_q;
   assign bus.bcd   = bcd_q;
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12000, clk cycles per displayed digit (minimum 2).
REQ-002 SHALL have parameter BLANK_LZ, default 1, 1 = blank leading zeros of digits 3..1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port inc  input  1  count request, synchronous to clk; one count per rising edge.
REQ-006 SHALL have port clr  input  1  synchronous clear of count and ovf.
REQ-007 SHALL have port en  input  1  count enable; scan runs regardless of en.
REQ-008 SHALL have port count  output  16  packed 4-digit BCD value, digit0 in [3:0].
REQ-009 SHALL have port ovf  output  1  sticky wrap flag.
REQ-010 SHALL have port bcd  output  4  selected digit code, feeding the 7-segment decoder.
REQ-011 SHALL have port dig_n  output  4  active-low one-hot digit select.

Function
REQ-012 SHALL detect an inc event as inc high while the previous-cycle registered inc was low; holding inc high gives exactly one event.
REQ-013 SHALL apply an inc event with en=1 on the same clk edge that first samples inc high; count reflects the change on the next cycle.
REQ-014 SHALL increment digit0; a digit at 9 SHALL become 0 and carry into the next digit; digits never hold codes above 9.
REQ-015 SHALL wrap 9999 to 0000 on an event and set ovf=1, held until clr or reset.
REQ-016 SHALL, on clr=1, load count=0x0000 and ovf=0; clr has priority over a simultaneous inc event and over en.
REQ-017 SHALL ignore inc events while en=0; the edge detector keeps tracking inc, so no event is generated when en later rises with inc already high.
REQ-018 SHALL run a prescaler from 0 to SCAN_DIV-1; at terminal count it returns to 0 and the scan index advances 0->1->2->3->0.
REQ-019 SHALL register dig_n = ~(1<<idx) and bcd = digit[idx] every cycle; both outputs change together, one cycle after idx or count changes.
REQ-020 SHALL, with BLANK_LZ=1, output bcd=4'hF for digit k (k=3..1) when digits 3..k are all zero; digit0 is never blanked.
REQ-021 SHALL output dig_n for a blanked digit normally; the decoder's code-above-9 default blanks it.

Reset
REQ-022 SHALL, with rst_n=0 at a clk edge, set count=0x0000, ovf=0, prescaler=0, idx=0, registered inc=0, dig_n=4'b1110, bcd=4'h0.
REQ-023 SHALL give reset priority over clr, inc and en, including mid-scan and mid-carry; no state survives reset.

Structure
REQ-024 SHALL place the digit count (4), blank code (4'hF) and default SCAN_DIV in a shared package, bcd_pkg.
REQ-025 SHALL implement each digit as sub-module bcd_digit (4-bit BCD counter with carry-in, carry-out and clear), instantiated four times in a ripple-carry chain.

Verification (SCAN_DIV=4 in simulation)
REQ-026 Reset: rst_n low 2 cycles -> count=0x0000, ovf=0, dig_n=1110, bcd=0.
REQ-027 Counting: 10 inc pulses -> count=0x0010; inc held high 5 cycles -> one increment only.
REQ-028 Wrap: drive count to 0x9999 plus one event -> count=0x0000, ovf=1; then clr -> ovf=0.
REQ-029 Priority: clr and inc rising in the same cycle at 0x0042 -> count=0x0000; en=0 with 3 pulses -> count unchanged.
REQ-030 Scan/blanking: count=0x0305, BLANK_LZ=1 -> dig_n 1110,1101,1011,0111 for 4 cycles each; bcd 5,0,3,F. At count=0x0005 -> bcd 5,F,F,F.
REQ-031 Mid-operation reset: rst_n low while idx=2 -> next cycle dig_n=1110, bcd=0, prescaler restarts from 0.
